// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO word packer.
package fifo_pkg;

    // Packer states: accumulating words, or holding a closed beat.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Bits needed to index one lane of a beat.
    function automatic int unsigned lane_idx_w(input int unsigned pack_ratio);
        return $clog2(pack_ratio);
    endfunction

    // Bits needed to express a lane count of 1..pack_ratio.
    function automatic int unsigned count_w(input int unsigned pack_ratio);
        return lane_idx_w(pack_ratio) + 1;
    endfunction

    // Position of the last flag inside an input word.
    function automatic int unsigned last_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO narrow FIFO words into one wide beat; a last-flagged word
// closes the beat early. One accumulator plus one output register.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PACK_RATIO = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH:0]                in_data_i,
    input  logic                               in_valid_i,
    output logic                               in_grant_o,
    output logic [PACK_RATIO*DATA_WIDTH-1:0]   out_data_o,
    output logic [count_w(PACK_RATIO)-1:0]     out_count_o,
    output logic                               out_last_o,
    output logic                               out_valid_o,
    input  logic                               out_grant_i
);

    localparam int unsigned LANE_IDX_W = lane_idx_w(PACK_RATIO);
    localparam int unsigned COUNT_W    = count_w(PACK_RATIO);
    localparam int unsigned BEAT_W     = PACK_RATIO * DATA_WIDTH;
    localparam int unsigned LAST_BIT   = last_bit(DATA_WIDTH);
    localparam logic [LANE_IDX_W-1:0] MAX_IDX = LANE_IDX_W'(PACK_RATIO - 1);

    state_e                  state_q, state_d;
    logic [LANE_IDX_W-1:0]   idx_q, idx_d;
    logic [BEAT_W-1:0]       acc_q, acc_d;
    logic [COUNT_W-1:0]      acc_count_q, acc_count_d;
    logic                    acc_last_q, acc_last_d;
    logic [BEAT_W-1:0]       out_data_q, out_data_d;
    logic [COUNT_W-1:0]      out_count_q, out_count_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_grant_q, in_grant_d;

    logic                    in_xfer;
    logic                    out_xfer;
    logic                    out_free;
    logic                    in_last;
    logic                    close_beat;
    logic [DATA_WIDTH-1:0]   payload;
    logic [BEAT_W-1:0]       merged;
    logic [COUNT_W-1:0]      close_count;

    // State and datapath registers; reset discards any partial or held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            acc_q       <= '0;
            acc_count_q <= '0;
            acc_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_grant_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            acc_count_q <= acc_count_d;
            acc_last_q  <= acc_last_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_grant_q  <= in_grant_d;
        end
    end

    // Next-state: accumulate, close beats, and move them to the output register.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        acc_count_d = acc_count_q;
        acc_last_d  = acc_last_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        in_xfer     = in_valid_i && in_grant_q;
        out_xfer    = out_valid_q && out_grant_i;
        out_free    = !out_valid_q || out_xfer;
        payload     = in_data_i[DATA_WIDTH-1:0];
        in_last     = in_data_i[LAST_BIT];
        close_beat  = (idx_q == MAX_IDX) || in_last;
        close_count = COUNT_W'(idx_q) + COUNT_W'(1);

        // Accumulator with the incoming word dropped into its lane.
        merged = acc_q;
        for (int unsigned k = 0; k < PACK_RATIO; k++) begin
            if (idx_q == LANE_IDX_W'(k)) begin
                merged[k*DATA_WIDTH +: DATA_WIDTH] = payload;
            end
        end

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (in_xfer) begin
                    if (close_beat) begin
                        idx_d = '0;
                        if (out_free) begin
                            out_data_d  = merged;
                            out_count_d = close_count;
                            out_last_d  = in_last;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                        end else begin
                            acc_d       = merged;
                            acc_count_d = close_count;
                            acc_last_d  = in_last;
                            state_d     = HOLD;
                        end
                    end else begin
                        acc_d = merged;
                        idx_d = idx_q + LANE_IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    out_data_d  = acc_q;
                    out_count_d = acc_count_q;
                    out_last_d  = acc_last_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    acc_count_d = '0;
                    acc_last_d  = 1'b0;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        in_grant_d = (state_d == FILL);
    end

    assign in_grant_o  = in_grant_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer (DATA_WIDTH=8, PACK_RATIO=4).
module tb_fifo_word_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PR = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_grant;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_last;
    logic        out_valid;
    logic        out_grant;

    int errors = 0;
    int checks = 0;

    beat_t       exp_q[$];
    logic [31:0] m_acc;
    int          m_idx;

    fifo_word_packer #(
        .DATA_WIDTH(DW),
        .PACK_RATIO(PR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_grant_o  (in_grant),
        .out_data_o  (out_data),
        .out_count_o (out_count),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_grant_i (out_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare every beat at the cycle it is consumed downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_grant) begin
            beat_t exp_b;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got data=%h count=%0d last=%0b, no beat expected",
                         out_data, out_count, out_last);
            end else begin
                exp_b = exp_q.pop_front();
                if ({out_data, out_count, out_last} !== exp_b) begin
                    errors++;
                    $display("FAIL sb_beat: got data=%h count=%0d last=%0b, expected data=%h count=%0d last=%0b",
                             out_data, out_count, out_last, exp_b.data, exp_b.count, exp_b.last);
                end
            end
        end
    end

    // Offer one word, wait (bounded) for acceptance, update the reference model.
    task automatic push_word(input logic [8:0] w, output int waited);
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_grant && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_grant) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %h not accepted after %0d cycles", w, waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_acc[m_idx*8 +: 8] = w[7:0];
        if (m_idx == PR - 1 || w[8]) begin
            exp_q.push_back('{data: m_acc, count: 3'(m_idx + 1), last: w[8]});
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_beat(input string name, input logic [31:0] d, input logic [2:0] c,
                              input logic l);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_count !== c || out_last !== l) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h count=%0d last=%0b, expected valid=1 data=%h count=%0d last=%0b",
                     name, out_valid, out_data, out_count, out_last, d, c, l);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_grant = 1'b1;
        m_acc     = '0;
        m_idx     = 0;
        #12;
        checks++;
        if ({out_valid, out_data, out_count, out_last, in_grant} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%h count=%0d last=%0b grant=%0b, expected all 0",
                     out_valid, out_data, out_count, out_last, in_grant);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_full_beat();
        int w;
        push_word(9'h011, w);
        push_word(9'h022, w);
        push_word(9'h033, w);
        push_word(9'h044, w);
        check_beat("full_beat", 32'h44332211, 3'd4, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_beat_one_cycle: got valid=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_early_last();
        int w;
        push_word(9'h0A1, w);
        push_word(9'h1A2, w);
        check_beat("early_last", 32'h0000A2A1, 3'd2, 1'b1);
        push_word(9'h0B3, w);
        push_word(9'h1B4, w);
        check_beat("early_last_restart", 32'h0000B4B3, 3'd2, 1'b1);
    endtask

    task automatic test_single_last();
        int w;
        push_word(9'h1FF, w);
        check_beat("single_last", 32'h000000FF, 3'd1, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int w;
        out_grant = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_word(9'(i), w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL bp_grant_word%0d: waited %0d cycles, expected 0", i, w);
            end
        end
        in_data  = 9'h009;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_grant !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h04030201) begin
                errors++;
                $display("FAIL bp_stall: got grant=%0b valid=%0b data=%h, expected grant=0 valid=1 data=04030201",
                         in_grant, out_valid, out_data);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_grant = 1'b1;
        @(posedge clk);
        #1;
        out_grant = 1'b0;
        check_beat("bp_second_beat", 32'h08070605, 3'd4, 1'b0);
        checks++;
        if (in_grant !== 1'b1) begin
            errors++;
            $display("FAIL bp_regrant: got grant=%0b, expected 1", in_grant);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_grant !== 1'b1 || out_data !== 32'h08070605) begin
            errors++;
            $display("FAIL bp_regrant_hold: got grant=%0b data=%h, expected grant=1 data=08070605",
                     in_grant, out_data);
        end
        out_grant = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        int w;
        out_grant = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_word(9'(8'h40 + i), w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL stream_grant_word%0d: waited %0d cycles, expected 0", i, w);
            end
            if (i % 4 == 3) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_beat%0d_valid: got valid=%0b, expected 1", i / 4, out_valid);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_beat();
        int w;
        out_grant = 1'b0;
        push_word(9'h0C1, w);
        push_word(9'h0C2, w);
        push_word(9'h0C3, w);
        push_word(9'h0C4, w);
        push_word(9'h0D1, w);
        push_word(9'h0D2, w);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_count, out_last, in_grant} !== '0) begin
            errors++;
            $display("FAIL reset_mid_beat: got valid=%0b data=%h count=%0d last=%0b grant=%0b, expected all 0",
                     out_valid, out_data, out_count, out_last, in_grant);
        end
        exp_q.delete();
        m_acc = '0;
        m_idx = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_grant = 1'b1;
        push_word(9'h011, w);
        push_word(9'h022, w);
        push_word(9'h033, w);
        push_word(9'h044, w);
        check_beat("reset_no_stale", 32'h44332211, 3'd4, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_early_last();
        test_single_last();
        test_backpressure();
        test_streaming();
        test_reset_mid_beat();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d beats never appeared, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the FIFO pop interface. It packs consecutive narrow FIFO words into one wide output beat of PACK_RATIO lanes. Bit DATA_WIDTH of each input word is a "last" marker that closes a beat early. The output is presented on a valid/grant handshake to the wide datapath, with one output register plus one accumulator for continuous throughput.

Parameters:
DATA_WIDTH, 32, payload bits per input word (input word is DATA_WIDTH+1 wide; MSB = last flag)
PACK_RATIO, 4, input words per output beat; must be a power of two and >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data_i  input  DATA_WIDTH+1  bits [DATA_WIDTH-1:0] payload; bit [DATA_WIDTH] last flag
in_valid_i  input  1  upstream (FIFO pop side) has a word
in_grant_o  output  1  packer accepts a word this cycle
out_data_o  output  PACK_RATIO*DATA_WIDTH  packed beat; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
out_count_o  output  $clog2(PACK_RATIO)+1  number of valid lanes in beat, 1..PACK_RATIO
out_last_o  output  1  beat was closed by a last-flagged word
out_valid_o  output  1  beat on out_* is valid
out_grant_i  input  1  downstream consumes beat

Behaviour:
- Reset (async assert, sync release): out_valid_o=0, out_data_o=0, out_count_o=0, out_last_o=0, in_grant_o=0 while rst_n low. Lane index=0, accumulator cleared, state FILL.
- Input transfer = in_valid_i && in_grant_o. Output transfer = out_valid_o && out_grant_i.
- States: FILL (accumulating), HOLD (closed beat waiting for output register).
- FILL: in_grant_o=1. Each input transfer writes the payload into lane[idx], and idx increments.
- A word closes the beat when idx==PACK_RATIO-1 or its last flag is set.
- Closing word, output register free: beat (accumulator merged with closing word) loads the output register at that edge. Idx returns to 0 and the accumulator clears. State stays FILL.
- "Output register free" = !out_valid_o || output transfer in the same cycle.
- Closing word, output register not free: the word is still accepted into the accumulator, and the state goes to HOLD.
- HOLD: in_grant_o=0. On an output transfer, the accumulator moves to the output register at that edge and the state goes to FILL. in_grant_o is 1 again the following cycle.
- Latency: beat is valid on out_valid_o one cycle after its closing word is accepted.
- Sustained throughput is 1 input word/cycle whenever the downstream grants at least once per PACK_RATIO cycles.
- Unused lanes (early last) are driven to 0.
- out_count_o = idx+1 of the closing word. out_last_o = last flag of the closing word.
- While out_valid_o && !out_grant_i, all out_* signals hold stable.
- out_grant_i without out_valid_o has no effect.
- in_data_i is ignored when in_valid_i=0 or in_grant_o=0.
- Reset mid-beat discards the partial accumulator and any held/pending beat. No partial beat is emitted after reset.
- Idx is an unsigned counter of $clog2(PACK_RATIO) bits; wrap from PACK_RATIO-1 to 0 is explicit, not overflow.

Decomposition:
- Shared package fifo_pkg:
  - state typedef {FILL, HOLD}
  - LANE_IDX_W = $clog2(PACK_RATIO) and COUNT_W = LANE_IDX_W+1, as package functions of PACK_RATIO
  - LAST_BIT index constant = DATA_WIDTH
- The module is kept flat; no sub-module is warranted, because the accumulator and output register share the close/load logic.

Test Plan:
Bench uses DATA_WIDTH=8, PACK_RATIO=4, and out_grant_i=1 unless stated.
- Full beat: push 0x011,0x022,0x033,0x044 back-to-back -> one cycle after the 4th word: out_data_o=0x44332211, out_count_o=4, out_last_o=0, out_valid_o=1 for one cycle.
- Early last: push 0x0A1, then 0x1A2 (last set) -> out_data_o=0x0000A2A1, out_count_o=2, out_last_o=1. Next beat starts at lane 0.
- Single-word last: push 0x1FF -> out_data_o=0x000000FF, out_count_o=1, out_last_o=1.
- Backpressure: hold out_grant_i=0 and push 8 words 0x01..0x08.
  - in_grant_o stays 1 for exactly 8 words, then 0; out_data_o=0x04030201 stays stable.
  - Raise out_grant_i for 1 cycle -> next cycle out_data_o=0x08070605; the cycle after, in_grant_o=1.
- Streaming: 12 consecutive words with out_grant_i=1 -> in_grant_o never drops; 3 beats appear, each one cycle after its 4th word.
- Reset mid-beat: push 2 words, pulse rst_n low -> out_valid_o=0 immediately. Push 0x011..0x044 after release -> out_data_o=0x44332211, out_count_o=4; no stale lanes.
